// File: rtl/slice_fill_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : slice_fill_pkg
// Purpose  : Shared types and helpers for the slice fill arbiter.
//            - state_t      : arbiter FSM states (IDLE / BURST)
//            - word_t       : one array word at the default width
//            - slice_legal  : checks that a (base, len) slice fits the array
// Revision : 1.0 - initial release
// ============================================================================
package slice_fill_pkg;

  localparam int c_word_width = 11;

  typedef logic [c_word_width-1:0] word_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Callers zero-extend the IW-bit config fields into 32 bits. The sum of
  // two IW-bit values needs at most IW+1 bits, so it can never wrap here.
  function automatic logic slice_legal(input int unsigned base,
                                       input int unsigned len,
                                       input int unsigned depth);
    return (len != 0) && ((base + len) <= depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/slice_fill_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : slice_fill_arbiter_if
// Purpose  : Requester-side handshake bundle of the slice fill arbiter.
//            req_valid [REQS]         requester offers a word
//            req_data  [REQS][WIDTH]  offered word per requester
//            req_ready [REQS]         one-hot or zero accept
//            master : producer side, slave : arbiter side
// Revision : 1.0 - initial release
// ============================================================================
interface slice_fill_arbiter_if #(
  parameter int WIDTH = 11,
  parameter int REQS  = 4
);

  logic [REQS-1:0]            req_valid;
  logic [REQS-1:0][WIDTH-1:0] req_data;
  logic [REQS-1:0]            req_ready;

  modport master (output req_valid, output req_data, input  req_ready);
  modport slave  (input  req_valid, input  req_data, output req_ready);

endinterface
`default_nettype wire

// File: rtl/slice_fill_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Round-robin first-set finder. Scans i_elig starting at i_rr,
//            wrapping modulo N, and returns the first set position.
//            i_elig  [N]  eligible mask
//            i_rr    [W]  scan start index
//            o_idx   [W]  first eligible index found (0 when none)
//            o_found      any eligible bit set
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] i_elig,
  input  logic [W-1:0] i_rr,
  output logic [W-1:0] o_idx,
  output logic         o_found
);

  int w_pos;

  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < N; k++) begin
      w_pos = int'(i_rr) + k;
      if (w_pos >= N) w_pos = w_pos - N;
      if (!o_found && i_elig[w_pos]) begin
        o_found = 1'b1;
        o_idx   = W'(w_pos);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/slice_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : slice_fill_arbiter
// Purpose  : Shares one write path into a registered word array among REQS
//            requesters. Each requester owns a runtime slice (base, len);
//            a granted requester streams exactly len words into its slice,
//            then arbitration moves on round-robin.
// Ports    : clock, reset          rising-edge clock, sync active-high reset
//            cfg_base/cfg_len     per-requester slice start and word count
//            bus (slave)          req_valid / req_data / req_ready
//            mem                  registered array contents
//            done                 slice fully written since last burst start
//            cfg_err              sticky: requested with an illegal slice
//            busy                 high while a burst is in progress
// Revision : 1.0 - initial release
// ============================================================================
module slice_fill_arbiter
  import slice_fill_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int DEPTH = 10,
  parameter int REQS  = 4,
  parameter int IW    = $clog2(DEPTH + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [REQS-1:0][IW-1:0]   cfg_base,
  input  logic [REQS-1:0][IW-1:0]   cfg_len,
  slice_fill_arbiter_if.slave       bus,
  output logic [WIDTH-1:0]          mem [DEPTH],
  output logic [REQS-1:0]           done,
  output logic [REQS-1:0]           cfg_err,
  output logic                      busy
);

  localparam int c_rw = (REQS > 1) ? $clog2(REQS) : 1;

  state_t            r_state;
  state_t            w_state_n;
  logic [c_rw-1:0]   r_rr;
  logic [c_rw-1:0]   r_g;
  logic [IW-1:0]     r_base;
  logic [IW-1:0]     r_len;
  logic [IW-1:0]     r_off;
  logic [REQS-1:0]   r_done;
  logic [REQS-1:0]   r_err;
  logic [WIDTH-1:0]  r_mem [DEPTH];

  logic [REQS-1:0]   w_legal;
  logic [REQS-1:0]   w_elig;
  logic [REQS-1:0]   w_bad;
  logic [c_rw-1:0]   w_pick;
  logic              w_found;
  logic              w_grant;
  logic              w_hs;
  logic              w_last;
  logic [IW-1:0]     w_addr;

  for (genvar i = 0; i < REQS; i++) begin : g_req
    assign w_legal[i] = slice_legal(32'(cfg_base[i]), 32'(cfg_len[i]), 32'(DEPTH));
    // Ready depends only on the state register, never on req_valid.
    assign bus.req_ready[i] = (r_state == BURST) && (r_g == c_rw'(i));
  end

  assign w_elig = bus.req_valid & w_legal;
  assign w_bad  = bus.req_valid & ~w_legal;

  rr_pick #(.N(REQS), .W(c_rw)) u_pick (
    .i_elig  (w_elig),
    .i_rr    (r_rr),
    .o_idx   (w_pick),
    .o_found (w_found)
  );

  // A legal slice guarantees base + offset < DEPTH, so IW bits suffice.
  assign w_addr = r_base + r_off;

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_grant   = 1'b0;
    w_hs      = 1'b0;
    w_last    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant   = 1'b1;
          w_state_n = BURST;
        end
      end
      BURST: begin
        w_hs   = bus.req_valid[r_g];
        w_last = w_hs && (r_off == r_len - IW'(1));
        if (w_last) w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr   <= '0;
      r_g    <= '0;
      r_base <= '0;
      r_len  <= '0;
      r_off  <= '0;
      r_done <= '0;
      r_err  <= '0;
    end else begin
      if (r_state == IDLE) r_err <= r_err | w_bad;
      if (w_grant) begin
        // Slice is latched here; later cfg changes only affect the next burst.
        r_g            <= w_pick;
        r_base         <= cfg_base[w_pick];
        r_len          <= cfg_len[w_pick];
        r_off          <= '0;
        r_done[w_pick] <= 1'b0;
      end
      if (w_hs) r_off <= r_off + IW'(1);
      if (w_last) begin
        r_done[r_g] <= 1'b1;
        r_rr        <= (r_g == c_rw'(REQS - 1)) ? '0 : r_g + c_rw'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int j = 0; j < DEPTH; j++) begin
      if (reset) begin
        r_mem[j] <= '0;
      end else if (w_hs && (w_addr == IW'(j))) begin
        r_mem[j] <= bus.req_data[r_g];
      end
    end
  end

  for (genvar j = 0; j < DEPTH; j++) begin : g_mem_out
    assign mem[j] = r_mem[j];
  end

  assign done    = r_done;
  assign cfg_err = r_err;
  assign busy    = (r_state == BURST);

endmodule
`default_nettype wire

// File: tb/tb_slice_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_slice_fill_arbiter
// Purpose  : Directed self-checking bench for slice_fill_arbiter. Expected
//            (requester, address) pairs are queued per scenario; every
//            accepted word pops one entry and the written word is checked
//            in mem on the following cycle against a shadow array.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_slice_fill_arbiter;
  import slice_fill_pkg::*;

  localparam int WIDTH = 11;
  localparam int DEPTH = 10;
  localparam int REQS  = 4;
  localparam int IW    = $clog2(DEPTH + 1);

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic [REQS-1:0][IW-1:0] cfg_base;
  logic [REQS-1:0][IW-1:0] cfg_len;
  logic [WIDTH-1:0]        mem [DEPTH];
  logic [REQS-1:0]         done;
  logic [REQS-1:0]         cfg_err;
  logic                    busy;

  always #5 clock = ~clock;

  slice_fill_arbiter_if #(.WIDTH(WIDTH), .REQS(REQS)) bus ();

  slice_fill_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .REQS(REQS), .IW(IW)) dut (
    .clock    (clock),
    .reset    (reset),
    .cfg_base (cfg_base),
    .cfg_len  (cfg_len),
    .bus      (bus),
    .mem      (mem),
    .done     (done),
    .cfg_err  (cfg_err),
    .busy     (busy)
  );

  typedef struct {
    int req;
    int addr;
  } exp_t;

  exp_t  sb[$];
  word_t exp_mem [DEPTH];
  int    rem [REQS];
  int    sent [REQS];
  int    stall_at [REQS];
  int    stall_cnt [REQS];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    pend_v;
  int    pend_addr;
  word_t pend_data;

  function automatic word_t word_of(int r, int k);
    return word_t'((r << 8) | ((k + 1) & 8'hff));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int r, input int a);
    exp_t e;
    e.req  = r;
    e.addr = a;
    sb.push_back(e);
  endtask

  task automatic set_slice(input int r, input int b, input int l, input int n);
    cfg_base[r] = IW'(b);
    cfg_len[r]  = IW'(l);
    rem[r]      = n;
  endtask

  // One clock: drive producers at negedge, score any handshake, then check
  // the written word just after the rising edge.
  task automatic step();
    logic [REQS-1:0] hs;
    int idx;
    exp_t e;
    @(negedge clock);
    for (int i = 0; i < REQS; i++) begin
      logic v;
      v = (rem[i] > 0);
      if (v && sent[i] == stall_at[i] && stall_cnt[i] > 0) begin
        v = 1'b0;
        stall_cnt[i]--;
      end
      bus.req_valid[i] = v;
      bus.req_data[i]  = word_of(i, sent[i]);
    end
    #1;
    chk("ready_onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
    hs     = bus.req_valid & bus.req_ready;
    pend_v = 1'b0;
    if (hs != '0) begin
      idx = 0;
      for (int i = 0; i < REQS; i++) if (hs[i]) idx = i;
      chk("grant_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("grant_req", 32'(idx), 32'(e.req));
        pend_v           = 1'b1;
        pend_addr        = e.addr;
        pend_data        = word_of(e.req, sent[e.req]);
        exp_mem[e.addr]  = pend_data;
      end
      sent[idx]++;
      rem[idx]--;
    end
    @(posedge clock);
    #1;
    if (pend_v) chk("mem_write", 32'(mem[pend_addr]), 32'(pend_data));
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic clear_model();
    for (int i = 0; i < REQS; i++) begin
      rem[i]       = 0;
      sent[i]      = 0;
      stall_at[i]  = -1;
      stall_cnt[i] = 0;
      cfg_base[i]  = '0;
      cfg_len[i]   = '0;
    end
    for (int j = 0; j < DEPTH; j++) exp_mem[j] = '0;
    sb.delete();
    pend_v = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_model();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic end_scn(input string tag);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    for (int j = 0; j < DEPTH; j++)
      chk({tag, "_mem"}, 32'(mem[j]), 32'(exp_mem[j]));
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    clear_model();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    for (int j = 0; j < DEPTH; j++) chk("rst_mem", 32'(mem[j]), 32'd0);
    reset = 1'b0;

    // Scenario 1: four slices filled in round-robin order
    set_slice(0, 0, 3, 3);
    set_slice(1, 3, 1, 1);
    set_slice(2, 4, 1, 1);
    set_slice(3, 5, 5, 5);
    for (int a = 0; a < 3; a++) push(0, a);
    push(1, 3);
    push(2, 4);
    for (int a = 5; a < 10; a++) push(3, a);
    run(13);
    chk("s1_done_13", 32'(done), 32'b0111);
    run(1);
    chk("s1_done_14", 32'(done), 32'b1111);
    chk("s1_busy_end", 32'(busy), 32'd0);
    end_scn("s1");

    // Scenario 2: stall of 3 cycles after 2 words
    do_reset();
    set_slice(1, 2, 4, 4);
    stall_at[1]  = 2;
    stall_cnt[1] = 3;
    for (int a = 2; a < 6; a++) push(1, a);
    run(5);
    chk("s2_busy_stall", 32'(busy), 32'd1);
    run(2);
    chk("s2_done_early", 32'(done), 32'b0000);
    run(1);
    chk("s2_done", 32'(done), 32'b0010);
    end_scn("s2");

    // Scenario 3: illegal slices (overrun and zero length) are flagged
    do_reset();
    set_slice(0, 0, 2, 2);
    set_slice(1, 2, 1, 1);
    set_slice(2, 8, 3, 3);
    set_slice(3, 5, 0, 3);
    push(0, 0);
    push(0, 1);
    push(1, 2);
    run(8);
    chk("s3_cfg_err", 32'(cfg_err), 32'b1100);
    chk("s3_done", 32'(done), 32'b0011);
    chk("s3_busy", 32'(busy), 32'd0);
    end_scn("s3");

    // Scenario 4: two continuously valid requesters alternate
    do_reset();
    set_slice(0, 0, 2, 4);
    set_slice(1, 2, 2, 4);
    for (int b = 0; b < 2; b++) begin
      push(0, 0); push(0, 1);
      push(1, 2); push(1, 3);
    end
    run(12);
    chk("s4_done", 32'(done), 32'b0011);
    end_scn("s4");

    // Scenario 5: reset mid-burst clears everything and rr
    do_reset();
    set_slice(0, 1, 1, 0);
    set_slice(1, 0, 1, 1);
    set_slice(2, 8, 3, 3);
    set_slice(3, 5, 5, 5);
    push(1, 0);
    push(3, 5);
    push(3, 6);
    run(5);
    chk("s5_pre_done", 32'(done), 32'b0010);
    chk("s5_pre_err", 32'(cfg_err), 32'b0100);
    reset = 1'b1;
    bus.req_valid = '0;
    @(posedge clock);
    #1;
    chk("s5_ready", 32'(bus.req_ready), 32'd0);
    chk("s5_busy", 32'(busy), 32'd0);
    chk("s5_done", 32'(done), 32'd0);
    chk("s5_cfg_err", 32'(cfg_err), 32'd0);
    for (int j = 0; j < DEPTH; j++) chk("s5_mem_clr", 32'(mem[j]), 32'd0);
    reset = 1'b0;
    sb.delete();
    for (int j = 0; j < DEPTH; j++) exp_mem[j] = '0;
    for (int i = 0; i < REQS; i++) sent[i] = 0;
    rem[0] = 1;
    rem[2] = 3;
    rem[3] = 5;
    push(0, 1);
    for (int a = 5; a < 10; a++) push(3, a);
    run(8);
    chk("s5_post_done", 32'(done), 32'b1001);
    chk("s5_post_err", 32'(cfg_err), 32'b0100);
    end_scn("s5");

    // Scenario 6: cfg_base change mid-burst only affects the next burst
    do_reset();
    set_slice(0, 0, 4, 8);
    for (int a = 0; a < 4; a++) push(0, a);
    for (int a = 6; a < 10; a++) push(0, a);
    run(3);
    cfg_base[0] = IW'(6);
    run(7);
    chk("s6_done", 32'(done), 32'b0001);
    end_scn("s6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/slice_fill_arbiter.md
Name: slice_fill_arbiter

Overview:
- Shares one write path into a registered, unpacked word array (`mem[DEPTH]`, WIDTH bits each) among REQS requesters.
- Each requester owns a runtime-configured contiguous slice (base, len) of the array.
- A granted requester streams exactly `len` words into its slice before another requester is served. Arbitration is round-robin per burst.
- Sits between chunk producers and the consumer that reads the whole array in parallel.

Parameters:
- WIDTH, 11, bits per array word
- DEPTH, 10, number of array words
- REQS, 4, number of requesters
- IW, $clog2(DEPTH+1), width of base/len config fields

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- cfg_base  input  [IW-1:0] x [REQS]  slice start index per requester
- cfg_len  input  [IW-1:0] x [REQS]  slice word count per requester
- req_valid  input  [REQS]  requester has a word / wants a burst
- req_data  input  [WIDTH-1:0] x [REQS]  word offered by each requester
- req_ready  output  [REQS]  one-hot or zero; word accepted on valid&ready
- mem  output  [WIDTH-1:0] x [DEPTH]  registered array contents
- done  output  [REQS]  slice fully written since last burst start
- cfg_err  output  [REQS]  sticky flag: requester asked with an illegal slice
- busy  output  1  high in BURST

Behaviour:
- Reset values:
  - all mem words 0
  - req_ready, done, cfg_err, busy all 0
  - state IDLE, round-robin pointer rr = 0
- Reset asserted mid-burst aborts the burst; words already written are cleared to 0.
- Slice legality: legal iff cfg_len >= 1 and cfg_base + cfg_len <= DEPTH, evaluated in IW+1 bits so there is no wrap.
- State IDLE:
  - Scan requesters starting at rr, wrapping modulo REQS.
  - The first one with req_valid and a legal slice wins.
  - Latch g, base_q, len_q, and offset = 0.
  - Clear done[g]; go to BURST next cycle.
  - req_ready is 0 in IDLE.
  - Every requester with req_valid and an illegal slice gets cfg_err set (sticky until reset) and is skipped.
  - No winner: stay in IDLE.
- State BURST:
  - req_ready[g] = 1 (combinational from state); all other ready bits 0.
  - On req_valid[g] & ready: mem[base_q+offset] <= req_data[g] at that edge, visible the next cycle. Then offset++.
  - req_valid low stalls without penalty.
  - When the handshake occurs with offset == len_q-1: set done[g], set rr = (g+1) mod REQS, return to IDLE.
- Timing:
  - cfg_* changes during a burst are ignored; only the latched values are used.
  - Minimum gap is one IDLE cycle between bursts, so a burst of L words takes L+1 cycles best case.
  - First accepted word is written 1 cycle after grant.
- Overlapping slices are legal; later writes overwrite.
- mem words outside the active slice hold their value.
- Single requester: re-granted every other cycle pair (IDLE, BURST...) without starvation of others.

Decomposition:
- Package slice_fill_pkg:
  - state enum {IDLE, BURST}
  - word_t typedef (logic [WIDTH-1:0])
  - function slice_legal(base, len, depth)
- Sub-module rr_pick: REQS-wide round-robin first-set finder taking eligible mask and rr, returning index and found flag. Reusable by other arbiters.

Test Plan:
- Four requesters with slices (0,3), (3,1), (4,1), (5,5), all valid from reset deassert.
  - Requester 0 writes 3 words, then 1 writes 1, then 2 writes 1, then 3 writes 5.
  - mem = written words in order; done = 4'b1111 after 3+1+1+5 words + 4 IDLE cycles = 14 cycles.
- Stall: requester 1, slice (2,4), drops valid for 3 cycles mid-burst after 2 words.
  - busy stays 1, offset holds; mem[2..5] correct; completes 3 cycles late.
- Illegal config: req 2 slice (8,3) with DEPTH=10, valid held.
  - cfg_err = 4'b0100, never granted; other requesters served normally.
  - len=0 also flags.
- Fairness: requesters 0 and 1 both continuously valid, each slice len 2.
  - Grants alternate 0,1,0,1; neither is granted twice in a row.
- Reset mid-burst: assert reset after 2 of 5 words.
  - Next cycle mem all 0, req_ready 0, busy 0, done 0, cfg_err 0; rr restarts at 0.
- Config change during burst: change cfg_base[0] from 0 to 6 mid-burst.
  - Remaining words still land at latched base 0; the next burst uses 6.
